decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised RV32I/RV64I instruction decode stage sitting between fetch and execute.
- Decodes each instruction combinationally on entry, then stores the decoded record in a DEPTH-entry FIFO.
- Both sides use a valid/ready handshake; a flush input supports branch redirect.
- Adds four things over a bare decoder: backpressure, an illegal-instruction flag, register-use flags, and optional M-extension decode.

Parameters:
- XLEN, 32, datapath width. Legal values are 32 and 64. Sets the imm and pc width and the shamt width.
- DEPTH, 2, output FIFO entries. Power of two, ≥2.
- M_EXT, 0, when 1 decodes mul/mulh/mulhsu/mulhu/div/divu/rem/remu. When 0 these decode as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all buffered entries and any input accepted this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded record available
- out_ready  in  1  execute accepts
- out_pc  out  XLEN  pc of the record
- out_instr_id  out  6  instruction ID from the shared ID header
- out_opcode  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_func3  out  3  instr[14:12]
- out_func7  out  7  instr[31:25]
- out_imm  out  XLEN  sign-extended immediate; zero for R-type
- out_shamt  out  $clog2(XLEN)  shift amount
- out_uses_rs1, out_uses_rs2, out_writes_rd  out  1 each  operand/writeback flags
- out_illegal  out  1  unrecognised encoding

Behaviour:
- Decode (combinational on in_instr):
  - Immediates follow the I/S/B/U/J formats, sign-extended to XLEN.
  - U-type is {instr[31:12],12'b0}, sign-extended to XLEN.
- Shifts:
  - shamt is instr[20+:$clog2(XLEN)].
  - srai/srli are distinguished by instr[30].
  - Remaining upper func7 bits must be zero, else illegal. For XLEN=64 this is instr[31,29:26]; for XLEN=32 it is instr[31,29:25].
- System instructions:
  - instr == 0x00000073 → ecall.
  - instr == 0x00100073 → ebreak.
  - func3=000 with any other encoding → illegal.
  - csr* are decoded by func3.
- R-type func7 handling:
  - 0000000 or 0100000 (the latter only for add/sub and srl/sra) → base ops.
  - 0000001 → M ops if M_EXT, else illegal.
  - Anything else → illegal.
- Illegal handling:
  - Illegal means out_illegal=1, instr_id=i_invalid, and all use flags 0.
  - Illegal records are still enqueued and still handshake.
- Use flags:
  - writes_rd = 0 for S, B, ecall, ebreak, and when rd==0.
  - uses_rs1 = 0 for lui, auipc, jal, csr*i, ecall, ebreak.
  - uses_rs2 = 1 only for R, S, B.
- FIFO: DEPTH entries with read/write pointers and a count of width $clog2(DEPTH)+1.
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready.
  - Pointers wrap modulo DEPTH.
- Handshake:
  - in_ready = (count != DEPTH) || pop. A combinational pass-through of out_ready is permitted only into the ready path.
  - out_valid = (count != 0). Outputs are driven from the head entry.
- Latency: an instruction accepted at edge N appears at the outputs after edge N (one-cycle latency when empty). There is no bypass.
- Simultaneous push and pop when full: both occur; count stays DEPTH.
- Simultaneous push and pop when empty: push only; pop is impossible because out_valid=0.
- Flush: at the next edge count=0 and pointers=0. A simultaneous push is dropped and a simultaneous pop is ignored.
- Reset, including mid-stream:
  - count=0 and pointers=0, so out_valid=0 and in_ready=1.
  - Data outputs read entry 0, which is reset to all-zero with instr_id=i_invalid, illegal=0.
- Outputs are held stable while out_valid && !out_ready.

Optional Feature:
- Macro DECODE_STATS_EN.
- Defined: adds out_decoded_cnt (32, output) and out_illegal_cnt (32, output).
  - decoded_cnt increments on each pop; illegal_cnt increments on each pop with illegal=1.
  - Both wrap at 2^32, clear on rst, and are unaffected by flush.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package decode_pkg holds:
  - the instruction-ID constants (6-bit; M ops appended after the base IDs);
  - the opcode localparams;
  - the decoded-record struct (pc, id, opcode, rd, rs1, rs2, func3, func7, imm, shamt, flags, illegal).
- Sub-module decode_comb: a purely combinational instr → record decoder, instantiated once before the FIFO write port.

Test Plan:
- addi: in 0x00500093, pc 0x100, out_ready=1 → next cycle out_valid=1, id=i_addi, rd=1, rs1=0, imm=5, uses_rs1=1, uses_rs2=0, writes_rd=1, out_pc=0x100.
- System and store decode:
  - 0x00100073 → i_ebreak, writes_rd=0.
  - 0x00000073 → i_ecall.
  - 0xFE112E23 (sw x1,-4(x2)) → i_sw, imm=0xFFFFFFFC, uses_rs2=1, writes_rd=0.
- Illegal and M_EXT: 0xFFFFFFFF → illegal=1, id=i_invalid. 0x02208033 (mul) with M_EXT=0 → illegal=1; with M_EXT=1 → i_mul.
- Backpressure, DEPTH=2:
  - Hold out_ready=0 and push 3 → in_ready=0 after 2 pushes.
  - Raise out_ready → records pop in order with no loss or duplication.
  - Push and pop in the same cycle while full → count stays 2.
- Flush: buffer 2 entries, assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the in-flight instruction never appears.
- XLEN=64: 0x4030D093 (srai x1,x1,3) → i_srai, shamt=3. 0x800000B7 (lui) → imm=0xFFFFFFFF80000000.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared decode definitions: instruction IDs, opcodes and the decoded-record layout.
// The record is sized for the widest datapath (64 bits); narrower builds truncate at the ports.
package decode_pkg;

  localparam int unsigned XlenMax  = 64;
  localparam int unsigned ShamtMax = 6;

  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpImm     = 7'b0010011;
  localparam logic [6:0] OpReg     = 7'b0110011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  // Base IDs first, M-extension IDs appended after them.
  typedef enum logic [5:0] {
    i_invalid = 6'd0,
    i_lui, i_auipc, i_jal, i_jalr,
    i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu,
    i_lb, i_lh, i_lw, i_lbu, i_lhu, i_lwu, i_ld,
    i_sb, i_sh, i_sw, i_sd,
    i_addi, i_slti, i_sltiu, i_xori, i_ori, i_andi, i_slli, i_srli, i_srai,
    i_add, i_sub, i_sll, i_slt, i_sltu, i_xor, i_srl, i_sra, i_or, i_and,
    i_fence, i_ecall, i_ebreak,
    i_csrrw, i_csrrs, i_csrrc, i_csrrwi, i_csrrsi, i_csrrci,
    i_mul, i_mulh, i_mulhsu, i_mulhu, i_div, i_divu, i_rem, i_remu
  } instr_id_e;

  typedef struct packed {
    logic [XlenMax-1:0]  pc;
    instr_id_e           id;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          func3;
    logic [6:0]          func7;
    logic [XlenMax-1:0]  imm;
    logic [ShamtMax-1:0] shamt;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } decoded_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I/RV64I (+ optional M) instruction decoder producing one record.
module decode_comb
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned M_EXT = 0
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output decoded_t        rec
);

  localparam bit Is64 = (XLEN == 64);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  assign opcode = instr[6:0];
  assign func3  = instr[14:12];
  assign func7  = instr[31:25];

  logic [XlenMax-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Bits above the shamt field must be zero; instr[30] alone selects srai/srli.
  logic slli_ok, sr_ok;
  assign slli_ok = Is64 ? (instr[31:26] == 6'b0) : (instr[31:25] == 7'b0);
  assign sr_ok   = !instr[31] && (Is64 ? (instr[29:26] == 4'b0) : (instr[29:25] == 5'b0));

  instr_id_e          id;
  logic [XlenMax-1:0] imm;
  logic               fmt_r, fmt_s, fmt_b, no_rs1, sys_trap, illegal;

  // Opcode/func decode to an instruction ID plus format information.
  always_comb begin
    id       = i_invalid;
    imm      = '0;
    fmt_r    = 1'b0;
    fmt_s    = 1'b0;
    fmt_b    = 1'b0;
    no_rs1   = 1'b0;
    sys_trap = 1'b0;
    case (opcode)
      OpLui:   begin id = i_lui;   imm = imm_u; no_rs1 = 1'b1; end
      OpAuipc: begin id = i_auipc; imm = imm_u; no_rs1 = 1'b1; end
      OpJal:   begin id = i_jal;   imm = imm_j; no_rs1 = 1'b1; end
      OpJalr: begin
        imm = imm_i;
        if (func3 == 3'b000) id = i_jalr;
      end
      OpBranch: begin
        imm   = imm_b;
        fmt_b = 1'b1;
        case (func3)
          3'b000:  id = i_beq;
          3'b001:  id = i_bne;
          3'b100:  id = i_blt;
          3'b101:  id = i_bge;
          3'b110:  id = i_bltu;
          3'b111:  id = i_bgeu;
          default: id = i_invalid;
        endcase
      end
      OpLoad: begin
        imm = imm_i;
        case (func3)
          3'b000:  id = i_lb;
          3'b001:  id = i_lh;
          3'b010:  id = i_lw;
          3'b011:  id = Is64 ? i_ld : i_invalid;
          3'b100:  id = i_lbu;
          3'b101:  id = i_lhu;
          3'b110:  id = Is64 ? i_lwu : i_invalid;
          default: id = i_invalid;
        endcase
      end
      OpStore: begin
        imm   = imm_s;
        fmt_s = 1'b1;
        case (func3)
          3'b000:  id = i_sb;
          3'b001:  id = i_sh;
          3'b010:  id = i_sw;
          3'b011:  id = Is64 ? i_sd : i_invalid;
          default: id = i_invalid;
        endcase
      end
      OpImm: begin
        imm = imm_i;
        case (func3)
          3'b000:  id = i_addi;
          3'b010:  id = i_slti;
          3'b011:  id = i_sltiu;
          3'b100:  id = i_xori;
          3'b110:  id = i_ori;
          3'b111:  id = i_andi;
          3'b001:  id = slli_ok ? i_slli : i_invalid;
          default: id = !sr_ok ? i_invalid : (instr[30] ? i_srai : i_srli);
        endcase
      end
      OpReg: begin
        fmt_r = 1'b1;
        case (func7)
          7'b0000000: begin
            case (func3)
              3'b000:  id = i_add;
              3'b001:  id = i_sll;
              3'b010:  id = i_slt;
              3'b011:  id = i_sltu;
              3'b100:  id = i_xor;
              3'b101:  id = i_srl;
              3'b110:  id = i_or;
              default: id = i_and;
            endcase
          end
          7'b0100000: begin
            if (func3 == 3'b000) id = i_sub;
            else if (func3 == 3'b101) id = i_sra;
          end
          7'b0000001: begin
            if (M_EXT != 0) begin
              case (func3)
                3'b000:  id = i_mul;
                3'b001:  id = i_mulh;
                3'b010:  id = i_mulhsu;
                3'b011:  id = i_mulhu;
                3'b100:  id = i_div;
                3'b101:  id = i_divu;
                3'b110:  id = i_rem;
                default: id = i_remu;
              endcase
            end
          end
          default: id = i_invalid;
        endcase
      end
      OpMiscMem: begin
        imm = imm_i;
        if (func3 == 3'b000) id = i_fence;
      end
      OpSystem: begin
        imm = imm_i;
        case (func3)
          3'b000: begin
            sys_trap = 1'b1;
            no_rs1   = 1'b1;
            if (instr == 32'h0000_0073) id = i_ecall;
            else if (instr == 32'h0010_0073) id = i_ebreak;
          end
          3'b001:  id = i_csrrw;
          3'b010:  id = i_csrrs;
          3'b011:  id = i_csrrc;
          3'b101:  begin id = i_csrrwi; no_rs1 = 1'b1; end
          3'b110:  begin id = i_csrrsi; no_rs1 = 1'b1; end
          3'b111:  begin id = i_csrrci; no_rs1 = 1'b1; end
          default: id = i_invalid;
        endcase
      end
      default: id = i_invalid;
    endcase
  end

  // Record assembly; an illegal encoding clears every use flag.
  always_comb begin
    illegal       = (id == i_invalid);
    rec           = '0;
    rec.pc        = XlenMax'(pc);
    rec.id        = id;
    rec.opcode    = opcode;
    rec.rd        = instr[11:7];
    rec.rs1       = instr[19:15];
    rec.rs2       = instr[24:20];
    rec.func3     = func3;
    rec.func7     = func7;
    rec.imm       = imm;
    rec.shamt     = Is64 ? instr[25:20] : {1'b0, instr[24:20]};
    rec.uses_rs1  = !illegal && !no_rs1;
    rec.uses_rs2  = !illegal && (fmt_r || fmt_s || fmt_b);
    rec.writes_rd = !illegal && !(fmt_s || fmt_b || sys_trap) && (instr[11:7] != 5'd0);
    rec.illegal   = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode into a DEPTH-entry FIFO with valid/ready on both sides.
// Optional macro DECODE_STATS_EN adds decoded/illegal pop counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned M_EXT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [5:0]               out_instr_id,
  output logic [6:0]               out_opcode,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [2:0]               out_func3,
  output logic [6:0]               out_func7,
  output logic [XLEN-1:0]          out_imm,
  output logic [$clog2(XLEN)-1:0]  out_shamt,
  output logic                     out_uses_rs1,
  output logic                     out_uses_rs2,
  output logic                     out_writes_rd,
  output logic                     out_illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]              out_decoded_cnt,
  output logic [31:0]              out_illegal_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ShW  = $clog2(XLEN);

  decoded_t dec, head;

  decode_comb #(
    .XLEN  (XLEN),
    .M_EXT (M_EXT)
  ) u_decode_comb (
    .instr (in_instr),
    .pc    (in_pc),
    .rec   (dec)
  );

  decoded_t        mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  // out_ready feeds only the ready path, so a full FIFO can still accept while draining.
  assign in_ready  = (count_q != CntW'(DEPTH)) || pop;
  assign push      = in_valid && in_ready && !flush;

  // Pointer/count next state; flush wins over any push or pop this cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state and storage; reset zeroes every entry so the head reads a clean record.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (push) mem_q[wptr_q] <= dec;
    end
  end

  assign head          = mem_q[rptr_q];
  assign out_pc        = head.pc[XLEN-1:0];
  assign out_instr_id  = head.id;
  assign out_opcode    = head.opcode;
  assign out_rd        = head.rd;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_func3     = head.func3;
  assign out_func7     = head.func7;
  assign out_imm       = head.imm[XLEN-1:0];
  assign out_shamt     = head.shamt[ShW-1:0];
  assign out_uses_rs1  = head.uses_rs1;
  assign out_uses_rs2  = head.uses_rs2;
  assign out_writes_rd = head.writes_rd;
  assign out_illegal   = head.illegal;

  // Upper record bits are dropped in 32-bit builds.
  logic unused_head;
  assign unused_head = ^{head.pc, head.imm, head.shamt};

`ifdef DECODE_STATS_EN
  logic [31:0] decoded_cnt_q, illegal_cnt_q;
  logic        pop_eff;
  assign pop_eff = pop && !flush;

  // Pop counters: cleared only by reset, wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else if (pop_eff) begin
      decoded_cnt_q <= decoded_cnt_q + 32'd1;
      if (head.illegal) illegal_cnt_q <= illegal_cnt_q + 32'd1;
    end
  end

  assign out_decoded_cnt = decoded_cnt_q;
  assign out_illegal_cnt = illegal_cnt_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit base build, a 32-bit M build and a 64-bit build
// all see the same input stream; only the base build experiences backpressure.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready, aux_ready;
  logic [31:0] in_instr, in_pc;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'b0, in_pc};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Base build outputs
  logic        a_in_ready, a_valid, a_rs1u, a_rs2u, a_wrd, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [5:0]  a_id;
  logic [6:0]  a_op, a_f7;
  logic [4:0]  a_rd, a_rs1, a_rs2, a_sh;
  logic [2:0]  a_f3;
  // M build outputs
  logic        m_in_ready, m_valid, m_rs1u, m_rs2u, m_wrd, m_ill;
  logic [31:0] m_pc, m_imm;
  logic [5:0]  m_id;
  logic [6:0]  m_op, m_f7;
  logic [4:0]  m_rd, m_rs1, m_rs2, m_sh;
  logic [2:0]  m_f3;
  // 64-bit build outputs
  logic        w_in_ready, w_valid, w_rs1u, w_rs2u, w_wrd, w_ill;
  logic [63:0] w_pc, w_imm;
  logic [5:0]  w_id;
  logic [6:0]  w_op, w_f7;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [5:0]  w_sh;
  logic [2:0]  w_f3;
`ifdef DECODE_STATS_EN
  logic [31:0] a_dcnt, a_icnt, m_dcnt, m_icnt, w_dcnt, w_icnt;
`endif

  decode_stage #(.XLEN(32), .DEPTH(2), .M_EXT(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_instr_id(a_id), .out_opcode(a_op), .out_rd(a_rd), .out_rs1(a_rs1),
    .out_rs2(a_rs2), .out_func3(a_f3), .out_func7(a_f7), .out_imm(a_imm), .out_shamt(a_sh),
    .out_uses_rs1(a_rs1u), .out_uses_rs2(a_rs2u), .out_writes_rd(a_wrd), .out_illegal(a_ill)
`ifdef DECODE_STATS_EN
    , .out_decoded_cnt(a_dcnt), .out_illegal_cnt(a_icnt)
`endif
  );

  decode_stage #(.XLEN(32), .DEPTH(2), .M_EXT(1)) dut_m (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_valid), .out_ready(aux_ready),
    .out_pc(m_pc), .out_instr_id(m_id), .out_opcode(m_op), .out_rd(m_rd), .out_rs1(m_rs1),
    .out_rs2(m_rs2), .out_func3(m_f3), .out_func7(m_f7), .out_imm(m_imm), .out_shamt(m_sh),
    .out_uses_rs1(m_rs1u), .out_uses_rs2(m_rs2u), .out_writes_rd(m_wrd), .out_illegal(m_ill)
`ifdef DECODE_STATS_EN
    , .out_decoded_cnt(m_dcnt), .out_illegal_cnt(m_icnt)
`endif
  );

  decode_stage #(.XLEN(64), .DEPTH(2), .M_EXT(0)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc64), .out_valid(w_valid), .out_ready(aux_ready),
    .out_pc(w_pc), .out_instr_id(w_id), .out_opcode(w_op), .out_rd(w_rd), .out_rs1(w_rs1),
    .out_rs2(w_rs2), .out_func3(w_f3), .out_func7(w_f7), .out_imm(w_imm), .out_shamt(w_sh),
    .out_uses_rs1(w_rs1u), .out_uses_rs2(w_rs2u), .out_writes_rd(w_wrd), .out_illegal(w_ill)
`ifdef DECODE_STATS_EN
    , .out_decoded_cnt(w_dcnt), .out_illegal_cnt(w_icnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; aux_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_id", 64'(a_id), 64'(i_invalid));
    check("rst_illegal", 64'(a_ill), 64'd0);
    check("rst_pc", 64'(a_pc), 64'd0);
    check("rst_imm", 64'(a_imm), 64'd0);

    // addi x1, x0, 5
    push(32'h0050_0093, 32'h100);
    check("addi_valid", 64'(a_valid), 64'd1);
    check("addi_id", 64'(a_id), 64'(i_addi));
    check("addi_rd", 64'(a_rd), 64'd1);
    check("addi_rs1", 64'(a_rs1), 64'd0);
    check("addi_imm", 64'(a_imm), 64'd5);
    check("addi_uses_rs1", 64'(a_rs1u), 64'd1);
    check("addi_uses_rs2", 64'(a_rs2u), 64'd0);
    check("addi_writes_rd", 64'(a_wrd), 64'd1);
    check("addi_pc", 64'(a_pc), 64'h100);

    push(32'h0010_0073, 32'h104);
    check("ebreak_id", 64'(a_id), 64'(i_ebreak));
    check("ebreak_writes_rd", 64'(a_wrd), 64'd0);
    check("ebreak_uses_rs1", 64'(a_rs1u), 64'd0);
    check("ebreak_illegal", 64'(a_ill), 64'd0);

    push(32'h0000_0073, 32'h108);
    check("ecall_id", 64'(a_id), 64'(i_ecall));

    // sw x1, -4(x2)
    push(32'hFE11_2E23, 32'h10C);
    check("sw_id", 64'(a_id), 64'(i_sw));
    check("sw_imm", 64'(a_imm), 64'hFFFF_FFFC);
    check("sw_uses_rs2", 64'(a_rs2u), 64'd1);
    check("sw_writes_rd", 64'(a_wrd), 64'd0);
    check("sw_rs1", 64'(a_rs1), 64'd2);
    check("sw_rs2", 64'(a_rs2), 64'd1);

    push(32'hFFFF_FFFF, 32'h110);
    check("ones_illegal", 64'(a_ill), 64'd1);
    check("ones_id", 64'(a_id), 64'(i_invalid));
    check("ones_uses_rs1", 64'(a_rs1u), 64'd0);
    check("ones_writes_rd", 64'(a_wrd), 64'd0);

    // mul x0, x1, x2
    push(32'h0220_8033, 32'h114);
    check("mul_noM_illegal", 64'(a_ill), 64'd1);
    check("mul_noM_id", 64'(a_id), 64'(i_invalid));
    check("mul_M_id", 64'(m_id), 64'(i_mul));
    check("mul_M_illegal", 64'(m_ill), 64'd0);
    check("mul_M_uses_rs2", 64'(m_rs2u), 64'd1);

    // lui x1, 0x80000
    push(32'h8000_00B7, 32'h118);
    check("lui32_id", 64'(a_id), 64'(i_lui));
    check("lui32_imm", 64'(a_imm), 64'h8000_0000);
    check("lui32_uses_rs1", 64'(a_rs1u), 64'd0);
    check("lui64_imm", w_imm, 64'hFFFF_FFFF_8000_0000);

    // srai x1, x1, 3
    push(32'h4030_D093, 32'h11C);
    check("srai64_id", 64'(w_id), 64'(i_srai));
    check("srai64_shamt", 64'(w_sh), 64'd3);
    check("srai32_id", 64'(a_id), 64'(i_srai));
    check("srai32_shamt", 64'(a_sh), 64'd3);

    // slli x1, x1, 32: legal only with a 6-bit shamt
    push(32'h0200_9093, 32'h120);
    check("slli32_illegal", 64'(a_ill), 64'd1);
    check("slli64_id", 64'(w_id), 64'(i_slli));
    check("slli64_shamt", 64'(w_sh), 64'd32);
    check("slli64_pc", w_pc, 64'h120);

    tick();
    check("drain_valid", 64'(a_valid), 64'd0);

    // Backpressure with DEPTH=2
    out_ready = 1'b0;
    push(32'h0010_0093, 32'h200);
    #1;
    check("bp1_valid", 64'(a_valid), 64'd1);
    check("bp1_in_ready", 64'(a_in_ready), 64'd1);
    push(32'h0020_0113, 32'h204);
    #1;
    check("bp2_in_ready", 64'(a_in_ready), 64'd0);
    check("bp2_pc", 64'(a_pc), 64'h200);
    push(32'h0030_0193, 32'h208);
    check("bp3_held_pc", 64'(a_pc), 64'h200);
    check("bp3_held_rd", 64'(a_rd), 64'd1);
    check("bp3_in_ready", 64'(a_in_ready), 64'd0);

    // Push and pop together while full
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0030_0193;
    in_pc     = 32'h208;
    #1;
    check("full_pp_in_ready", 64'(a_in_ready), 64'd1);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("full_pp_pc", 64'(a_pc), 64'h204);
    check("full_pp_still_full", 64'(a_in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("order_pc3", 64'(a_pc), 64'h208);
    check("order_rd3", 64'(a_rd), 64'd3);
    check("order_valid3", 64'(a_valid), 64'd1);
    tick();
    check("order_empty", 64'(a_valid), 64'd0);

    // Flush with a simultaneous push
    out_ready = 1'b0;
    push(32'h0010_0093, 32'h300);
    push(32'h0020_0113, 32'h304);
    in_valid = 1'b1;
    in_instr = 32'h0030_0193;
    in_pc    = 32'h308;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", 64'(a_valid), 64'd0);
    check("flush_in_ready", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    check("flush_no_ghost", 64'(a_valid), 64'd0);
    push(32'h0040_0213, 32'h30C);
    check("post_flush_pc", 64'(a_pc), 64'h30C);
    check("post_flush_rd", 64'(a_rd), 64'd4);

    // Mid-stream reset
    out_ready = 1'b0;
    push(32'h0050_0293, 32'h400);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mrst_valid", 64'(a_valid), 64'd0);
    check("mrst_in_ready", 64'(a_in_ready), 64'd1);
    check("mrst_id", 64'(a_id), 64'(i_invalid));
    check("mrst_pc", 64'(a_pc), 64'd0);
    check("mrst_rd", 64'(a_rd), 64'd0);
`ifdef DECODE_STATS_EN
    check("mrst_dcnt", 64'(a_dcnt), 64'd0);
    check("mrst_icnt", 64'(a_icnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
